// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB3 initiator: command stream in, one APB transfer at a time, response stream out (optional APB_MST_TIMEOUT_EN)
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // The wait counter is 16 bits wide, so the limit must fit in it and be non-zero.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_cmd_master: TIMEOUT_CYCLES out of range 1..65535");
    end

    logic [1:0] state;

`ifdef APB_MST_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt;
`endif

    // Main FSM; every output is a register updated alongside the state transition.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        PADDR     <= req_addr;
                        PWDATA    <= req_wdata;
                        PWRITE    <= req_write;
                        PSEL      <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE  <= 1'b1;
                    state    <= ST_ACCESS;
`ifdef APB_MST_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        // Read data is only meaningful for reads; writes report zero.
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= ST_RESP;
                    end
`ifdef APB_MST_TIMEOUT_EN
                    else if (wait_cnt + 16'd1 == TIMEOUT_LIM) begin
                        // Slave never answered: abandon the transfer and flag an error.
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - randomized self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

    localparam int TO = 4;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int total = 0;
    int bad   = 0;

    apb_cmd_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference response of a completed transfer, straight from the response rules.
    function automatic logic [31:0] model_rdata(input bit wr, input logic [31:0] prd);
        return wr ? 32'd0 : prd;
    endfunction

    // One full transfer. Inputs change on negedge, outputs sampled on negedge.
    task automatic do_xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                           input int waits, input bit err, input logic [31:0] prd,
                           input int stall);
        logic [31:0] exp_rd;
        exp_rd = model_rdata(wr, prd);
        check_val("idle_req_ready", 32'(req_ready), 1);
        check_val("idle_busy", 32'(busy), 0);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(posedge HCLK); @(negedge HCLK);
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_write = ~wr;
        check_val("setup_psel", 32'(PSEL), 1);
        check_val("setup_penable", 32'(PENABLE), 0);
        check_val("setup_req_ready", 32'(req_ready), 0);
        check_val("setup_paddr", 32'(PADDR), 32'(a));
        check_val("setup_pwdata", PWDATA, d);
        check_val("setup_pwrite", 32'(PWRITE), 32'(wr));
        @(posedge HCLK); @(negedge HCLK);
        for (int i = 0; i <= waits; i++) begin
            check_val("access_penable", 32'(PENABLE), 1);
            check_val("access_psel", 32'(PSEL), 1);
            check_val("access_paddr", 32'(PADDR), 32'(a));
            check_val("access_rsp_valid", 32'(rsp_valid), 0);
            PREADY  = (i == waits);
            PSLVERR = (i == waits) ? err : $urandom_range(0, 1);
            PRDATA  = (i == waits) ? prd : $urandom;
            @(posedge HCLK); @(negedge HCLK);
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        check_val("resp_valid", 32'(rsp_valid), 1);
        check_val("resp_rdata", rsp_rdata, exp_rd);
        check_val("resp_err", 32'(rsp_err), 32'(err));
        check_val("resp_psel", 32'(PSEL), 0);
        check_val("resp_penable", 32'(PENABLE), 0);
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1; req_addr = 12'($urandom);
            @(posedge HCLK); @(negedge HCLK);
            check_val("stall_req_ready", 32'(req_ready), 0);
            check_val("stall_psel", 32'(PSEL), 0);
            check_val("stall_rsp_valid", 32'(rsp_valid), 1);
            check_val("stall_rdata", rsp_rdata, exp_rd);
            check_val("stall_err", 32'(rsp_err), 32'(err));
            check_val("stall_paddr_hold", 32'(PADDR), 32'(a));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge HCLK); @(negedge HCLK);
        rsp_ready = 1'b0;
        check_val("post_rsp_valid", 32'(rsp_valid), 0);
        check_val("post_req_ready", 32'(req_ready), 1);
        check_val("post_busy", 32'(busy), 0);
    endtask

    // Start a transfer and stop in ACCESS with PREADY low.
    task automatic start_hang(input logic [11:0] a);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        @(posedge HCLK); @(negedge HCLK);
        req_valid = 1'b0;
        @(posedge HCLK); @(negedge HCLK);
        check_val("hang_penable", 32'(PENABLE), 1);
    endtask

    task automatic pulse_reset();
        HRESET = 1'b1;
        @(posedge HCLK); @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check_val("rst_req_ready", 32'(req_ready), 1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 0);
        check_val("rst_psel", 32'(PSEL), 0);
        check_val("rst_penable", 32'(PENABLE), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_paddr", 32'(PADDR), 0);
        check_val("rst_rsp_rdata", rsp_rdata, 0);
        HRESET = 1'b0;

        do_xfer(1'b1, 12'h048, 32'h1234_5678, 0, 1'b0, 32'hCAFE_F00D, 0);
        do_xfer(1'b0, 12'h004, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 0);
        do_xfer(1'b0, 12'h010, 32'h0, 1, 1'b1, 32'h0000_00A5, 2);
        do_xfer(1'b1, 12'h020, 32'hFFFF_0000, 0, 1'b0, 32'h1111_1111, 5);

        for (int n = 0; n < 40; n++) begin
            do_xfer(1'($urandom_range(0, 1)), 12'($urandom), $urandom,
                    $urandom_range(0, TO - 1), 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(0, 3));
        end

        start_hang(12'h100);
        PRDATA = 32'h5A5A_5A5A;
        HRESET = 1'b1;
        @(posedge HCLK); @(negedge HCLK);
        HRESET = 1'b0;
        check_val("abort_psel", 32'(PSEL), 0);
        check_val("abort_penable", 32'(PENABLE), 0);
        check_val("abort_req_ready", 32'(req_ready), 1);
        check_val("abort_rsp_valid", 32'(rsp_valid), 0);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_val("abort_no_rsp", 32'(rsp_valid), 0);
        check_val("abort_idle_busy", 32'(busy), 0);

        start_hang(12'h200);
`ifdef APB_MST_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            @(posedge HCLK); @(negedge HCLK);
            check_val("to_still_access", 32'(PENABLE), 1);
        end
        @(posedge HCLK); @(negedge HCLK);
        check_val("to_rsp_valid", 32'(rsp_valid), 1);
        check_val("to_rsp_err", 32'(rsp_err), 1);
        check_val("to_rsp_rdata", rsp_rdata, 0);
        check_val("to_psel", 32'(PSEL), 0);
        rsp_ready = 1'b1;
        @(posedge HCLK); @(negedge HCLK);
        rsp_ready = 1'b0;
        check_val("to_post_req_ready", 32'(req_ready), 1);
`else
        repeat (20) @(posedge HCLK);
        @(negedge HCLK);
        check_val("hang_busy", 32'(busy), 1);
        check_val("hang_rsp_valid", 32'(rsp_valid), 0);
        check_val("hang_penable_held", 32'(PENABLE), 1);
        pulse_reset();
        check_val("hang_reset_idle", 32'(req_ready), 1);
`endif
        PRDATA = 32'h0;
        do_xfer(1'b0, 12'h3FC, 32'h0, 2, 1'b0, 32'h0BAD_CAFE, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
